// File: rtl/sys_counter_csr_unit_if.sv
// ---------------------------------------------------------------------------
// sys_counter_csr_unit_if
// Purpose : CSR request/response bus between the execute stage and the
//           counter CSR unit. One request per cycle, response one cycle later,
//           no backpressure.
// Signals :
//   i_req_valid  request present this cycle
//   i_req_addr   12-bit CSR address
//   i_req_we     1 = write i_req_wdata, 0 = read
//   i_req_wdata  write data
//   o_rsp_valid  response for the previous cycle's request
//   o_rsp_rdata  read data (old CSR value on writes, 0 on error)
//   o_rsp_err    illegal address or write to a read-only CSR
// Modports: master = execute stage, slave = counter unit.
// ---------------------------------------------------------------------------
interface sys_counter_csr_unit_if #(
    parameter int DATA_SIZE = 32
);
    logic                 i_req_valid;
    logic [11:0]          i_req_addr;
    logic                 i_req_we;
    logic [DATA_SIZE-1:0] i_req_wdata;
    logic                 o_rsp_valid;
    logic [DATA_SIZE-1:0] o_rsp_rdata;
    logic                 o_rsp_err;

    modport master (
        output i_req_valid, i_req_addr, i_req_we, i_req_wdata,
        input  o_rsp_valid, o_rsp_rdata, o_rsp_err
    );

    modport slave (
        input  i_req_valid, i_req_addr, i_req_we, i_req_wdata,
        output o_rsp_valid, o_rsp_rdata, o_rsp_err
    );
endinterface

// File: rtl/sys_counter_csr_unit.sv
// ---------------------------------------------------------------------------
// sys_counter_csr_unit
// Purpose : RV32 Zicntr/Zihpm counter CSR block. Holds cycle, time, instret
//           and NUM_HPM event counters; serves CSR reads/writes with a fixed
//           one-cycle registered response.
// Ports   :
//   i_aclk       clock, all state on posedge
//   i_areset     asynchronous active-high reset
//   csr          sys_counter_csr_unit_if.slave request/response bus
//   i_instret    one instruction retired this cycle
//   i_hpm_event  per-HPM increment pulse (width max(NUM_HPM,1))
// Parameters: TIME_CNT_PER (clocks per time tick), CNT_WIDTH (33..64),
//           NUM_HPM (0..29).
// Optional feature: define SYS_CNT_SHADOW_EN to latch the high half of a
//           counter on each low-half read, so a low/high read pair is atomic.
// Counter index: 0 cycle, 1 time, 2 instret, 3+k hpm k. The low seven
// address bits select the index, bit 7 selects the high half.
// ---------------------------------------------------------------------------
module sys_counter_csr_unit #(
    parameter int TIME_CNT_PER = 1024,
    parameter int CNT_WIDTH    = 64,
    parameter int NUM_HPM      = 4
) (
    input  logic                                   i_aclk,
    input  logic                                   i_areset,
    sys_counter_csr_unit_if.slave                  csr,
    input  logic                                   i_instret,
    input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] i_hpm_event
);
    localparam int          DATA_SIZE = 32;
    localparam int          NC        = 3 + NUM_HPM;
    localparam int          HW        = CNT_WIDTH - 32;
    localparam int          PW        = (TIME_CNT_PER > 1) ? $clog2(TIME_CNT_PER) : 1;
    localparam logic [63:0] HPM_BITS  = ((64'd1 << NUM_HPM) - 64'd1) << 3;
    localparam logic [31:0] INH_MASK  = HPM_BITS[31:0] | 32'h0000_0005;

    logic [CNT_WIDTH-1:0] r_cnt [NC];
    logic [31:0]          r_inh;
    logic [PW-1:0]        r_presc;
    logic                 r_tick;
    logic                 r_rsp_valid;
    logic                 r_rsp_err;
    logic [DATA_SIZE-1:0] r_rsp_rdata;

`ifdef SYS_CNT_SHADOW_EN
    logic                 r_sh_vld;
    logic [6:0]           r_sh_id;
    logic [31:0]          r_sh_val;
`endif

    logic [11:0]          w_addr;
    logic [6:0]           w_id;
    logic                 w_hi;
    logic                 w_user;
    logic                 w_mach;
    logic                 w_inh_sel;
    logic                 w_id_ok;
    logic                 w_cnt_sel;
    logic                 w_err;
    logic                 w_rd;
    logic                 w_cnt_wr;
    logic                 w_inh_wr;
    logic                 w_sh_hit;
    logic [31:0]          w_sh_val;
    logic [63:0]          w_sel;
    logic [31:0]          w_live;
    logic [DATA_SIZE-1:0] w_rdata;
    logic [NC-1:0]        w_inc;

    // Address decode and read mux.
    always_comb begin
        w_addr    = csr.i_req_addr;
        w_id      = w_addr[6:0];
        w_hi      = w_addr[7];
        w_user    = (w_addr[11:8] == 4'hC);
        w_mach    = (w_addr[11:8] == 4'hB);
        w_inh_sel = (w_addr == 12'h320);
        // time has no machine alias
        w_id_ok   = ({25'd0, w_id} < 32'(NC)) && !(w_mach && (w_id == 7'd1));
        w_cnt_sel = (w_user || w_mach) && w_id_ok;
        w_err     = !(w_cnt_sel || w_inh_sel) || (w_user && csr.i_req_we);
        w_rd      = csr.i_req_valid && !w_err && !csr.i_req_we;
        w_cnt_wr  = csr.i_req_valid && !w_err && csr.i_req_we && w_cnt_sel;
        w_inh_wr  = csr.i_req_valid && csr.i_req_we && w_inh_sel;

        w_sel = '0;
        for (int i = 0; i < NC; i++) begin
            if (w_id == 7'(i)) w_sel = 64'(r_cnt[i]);
        end
        w_live = w_hi ? w_sel[63:32] : w_sel[31:0];

`ifdef SYS_CNT_SHADOW_EN
        w_sh_hit = w_rd && w_cnt_sel && w_hi && r_sh_vld && (r_sh_id == w_id);
        w_sh_val = r_sh_val;
`else
        w_sh_hit = 1'b0;
        w_sh_val = '0;
`endif

        if (w_err)          w_rdata = '0;
        else if (w_inh_sel) w_rdata = r_inh;
        else if (w_sh_hit)  w_rdata = w_sh_val;
        else                w_rdata = w_live;
    end

    // Increment enables use the inhibit value already registered, so an
    // mcountinhibit write only affects the following cycle.
    always_comb begin
        w_inc    = '0;
        w_inc[0] = !r_inh[0];
        w_inc[1] = r_tick;
        w_inc[2] = i_instret && !r_inh[2];
        for (int k = 0; k < NUM_HPM; k++) begin
            w_inc[3+k] = i_hpm_event[k] && !r_inh[3+k];
        end
    end

    // Counters, inhibit and time prescaler. A written counter skips its
    // increment that cycle. The tick is registered off the prescaler wrap to
    // keep the wrap compare out of the time adder path.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            for (int i = 0; i < NC; i++) r_cnt[i] <= '0;
            r_inh   <= '0;
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (w_cnt_wr && (w_id == 7'(i))) begin
                    if (w_hi) r_cnt[i][CNT_WIDTH-1:32] <= csr.i_req_wdata[HW-1:0];
                    else      r_cnt[i][31:0]           <= csr.i_req_wdata;
                end else if (w_inc[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
                end
            end
            if (w_inh_wr) r_inh <= csr.i_req_wdata & INH_MASK;
            if (r_presc == PW'(TIME_CNT_PER - 1)) begin
                r_presc <= '0;
                r_tick  <= 1'b1;
            end else begin
                r_presc <= r_presc + PW'(1);
                r_tick  <= 1'b0;
            end
        end
    end

    // Response register; rdata holds when no request.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= csr.i_req_valid;
            r_rsp_err   <= csr.i_req_valid && w_err;
            if (csr.i_req_valid) r_rsp_rdata <= w_rdata;
        end
    end

`ifdef SYS_CNT_SHADOW_EN
    // Single shadow: the most recent low-half read owns it.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_sh_vld <= 1'b0;
            r_sh_id  <= '0;
            r_sh_val <= '0;
        end else if (w_rd && w_cnt_sel && !w_hi) begin
            r_sh_vld <= 1'b1;
            r_sh_id  <= w_id;
            r_sh_val <= w_sel[63:32];
        end else if (w_sh_hit) begin
            r_sh_vld <= 1'b0;
        end else if (w_cnt_wr && (w_id == r_sh_id)) begin
            r_sh_vld <= 1'b0;
        end
    end
`endif

    assign csr.o_rsp_valid = r_rsp_valid;
    assign csr.o_rsp_err   = r_rsp_err;
    assign csr.o_rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_sys_counter_csr_unit.sv
// ---------------------------------------------------------------------------
// tb_sys_counter_csr_unit
// Bench for sys_counter_csr_unit (TIME_CNT_PER=4, CNT_WIDTH=48, NUM_HPM=4).
// A cycle-level reference model predicts every response; directed sequences
// pin a few hand-computed values, then a randomized phase with a mid-run
// reset follows. Honors SYS_CNT_SHADOW_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_sys_counter_csr_unit;
    localparam int P  = 4;
    localparam int CW = 48;
    localparam int NH = 4;
    localparam int NC = 3 + NH;
`ifdef SYS_CNT_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    bit          clk = 1'b0;
    bit          rst = 1'b1;
    logic        instret = 1'b0;
    logic [NH-1:0] hpm = '0;

    sys_counter_csr_unit_if #(.DATA_SIZE(32)) bus ();

    sys_counter_csr_unit #(
        .TIME_CNT_PER(P), .CNT_WIDTH(CW), .NUM_HPM(NH)
    ) dut (
        .i_aclk      (clk),
        .i_areset    (rst),
        .csr         (bus),
        .i_instret   (instret),
        .i_hpm_event (hpm)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] CMASK;
    logic [31:0] INH_MASK;
    int          amap [int];     // address -> id*4 + hi*2 + user
    int          legal [$];
    logic [63:0] m_cnt [NC];
    logic [31:0] m_inh;
    int unsigned m_n;            // cycles since reset release
    bit          m_sh_vld;
    int          m_sh_id;
    logic [31:0] m_sh_val;
    bit          e_vld = 1'b0;
    logic [31:0] e_rdata = '0;
    bit          e_err = 1'b0;

    // time = number of completed prescaler periods, seen one cycle late
    function automatic logic [63:0] cur(input int id);
        if (id == 1) return (m_n == 0) ? 64'd0 : 64'((m_n - 1) / P);
        return m_cnt[id];
    endfunction

    task automatic model_step();
        logic [63:0] v;
        logic [31:0] inh_n, wd;
        int a, code, id, wid;
        bit hi, en;
        if (rst) begin
            foreach (m_cnt[i]) m_cnt[i] = '0;
            m_inh = '0; m_n = 0; m_sh_vld = 0; m_sh_id = 0; m_sh_val = '0;
            e_vld = 0; e_rdata = '0; e_err = 0;
            return;
        end
        wid   = -1;
        hi    = 0;
        inh_n = m_inh;
        wd    = bus.i_req_wdata;
        a     = {20'd0, bus.i_req_addr};
        e_vld = bus.i_req_valid;
        if (bus.i_req_valid) begin
            if (a == 'h320) begin
                e_err = 0; e_rdata = m_inh;
                if (bus.i_req_we) inh_n = wd & INH_MASK;
            end else if (!amap.exists(a) || ((a >> 8) == 'hC && bus.i_req_we)) begin
                e_err = 1; e_rdata = '0;
            end else begin
                code  = amap[a];
                id    = code >> 2;
                hi    = ((code >> 1) & 1) != 0;
                v     = cur(id);
                e_err = 0;
                if (hi) begin
                    e_rdata = v[63:32];
                    if (SHADOW && !bus.i_req_we && m_sh_vld && m_sh_id == id) begin
                        e_rdata  = m_sh_val;
                        m_sh_vld = 0;
                    end
                end else begin
                    e_rdata = v[31:0];
                    if (SHADOW && !bus.i_req_we) begin
                        m_sh_vld = 1; m_sh_id = id; m_sh_val = v[63:32];
                    end
                end
                if (bus.i_req_we) begin
                    wid = id;
                    if (m_sh_id == id) m_sh_vld = 0;
                end
            end
        end
        for (int i = 0; i < NC; i++) begin
            if (i == 1) continue;
            if (i == wid) begin
                if (hi) m_cnt[i] = ((64'(wd) << 32) | 64'(m_cnt[i][31:0])) & CMASK;
                else    m_cnt[i] = {m_cnt[i][63:32], wd};
            end else begin
                if (i == 0)      en = !m_inh[0];
                else if (i == 2) en = instret && !m_inh[2];
                else             en = hpm[i-3] && !m_inh[i];
                if (en) m_cnt[i] = (m_cnt[i] + 64'd1) & CMASK;
            end
        end
        m_inh = inh_n;
        m_n++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- compare process ----------------
    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("rst_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
            chk("rst_rdata", bus.o_rsp_rdata, 32'd0);
            chk("rst_err",   {31'd0, bus.o_rsp_err}, 32'd0);
        end else begin
            chk("rsp_valid", {31'd0, bus.o_rsp_valid}, {31'd0, e_vld});
            chk("rsp_rdata", bus.o_rsp_rdata, e_rdata);
            if (e_vld) chk("rsp_err", {31'd0, bus.o_rsp_err}, {31'd0, e_err});
        end
    end

    // ---------------- driver ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic req(input logic [11:0] a, input bit we, input logic [31:0] d,
                       output logic [31:0] rd, output bit er, output bit vl);
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = a;
        bus.i_req_we    = we;
        bus.i_req_wdata = d;
        @(posedge clk); #1;
        bus.i_req_valid = 1'b0;
        bus.i_req_we    = 1'b0;
        rd = bus.o_rsp_rdata;
        er = bus.o_rsp_err;
        vl = bus.o_rsp_valid;
    endtask

    initial begin
        logic [31:0] rd, t0;
        bit er, vl;
        logic [11:0] a;

        CMASK    = (CW == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CW) - 64'd1);
        INH_MASK = 32'h5;
        for (int k = 0; k < NH; k++) INH_MASK = INH_MASK | (32'd1 << (3 + k));
        for (int id = 0; id < NC; id++) begin
            amap['hC00 + id] = id * 4 + 1;
            amap['hC80 + id] = id * 4 + 3;
            legal.push_back('hC00 + id);
            legal.push_back('hC80 + id);
            if (id != 1) begin
                amap['hB00 + id] = id * 4;
                amap['hB80 + id] = id * 4 + 2;
                legal.push_back('hB00 + id);
                legal.push_back('hB80 + id);
            end
        end

        bus.i_req_valid = 1'b0;
        bus.i_req_addr  = '0;
        bus.i_req_we    = 1'b0;
        bus.i_req_wdata = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // cycle count after 10 idle cycles
        idle(10);
        req(12'hC00, 0, 0, rd, er, vl);
        chk("c00_after_10", rd, 32'd10);
        chk("c00_err", {31'd0, er}, 32'd0);
        chk("c00_valid", {31'd0, vl}, 32'd1);

        // carry from low into high half
        req(12'hB80, 1, 32'h0, rd, er, vl);
        req(12'hB00, 1, 32'hFFFF_FFFF, rd, er, vl);
        idle(1);
        req(12'hC80, 0, 0, rd, er, vl);
        chk("cycle_carry_hi", rd, 32'd1);

        // instret inhibit then release
        req(12'h320, 1, 32'h4, rd, er, vl);
        instret = 1'b1; idle(5); instret = 1'b0;
        req(12'hC02, 0, 0, rd, er, vl);
        chk("instret_inhibited", rd, 32'd0);
        req(12'h320, 1, 32'h0, rd, er, vl);
        chk("inh_old_value", rd, 32'h4);
        instret = 1'b1; idle(3); instret = 1'b0;
        req(12'hC02, 0, 0, rd, er, vl);
        chk("instret_plus3", rd, 32'd3);

        // time: 16 cycles at 4 per tick
        req(12'hC01, 0, 0, t0, er, vl);
        idle(15);
        req(12'hC01, 0, 0, rd, er, vl);
        chk("time_delta", rd - t0, 32'd4);

        // error cases
        req(12'hC00, 1, 32'h1234, rd, er, vl);
        chk("wr_c00_err", {31'd0, er}, 32'd1);
        chk("wr_c00_rdata", rd, 32'd0);
        req(12'h7FF, 0, 0, rd, er, vl);
        chk("rd_7ff_err", {31'd0, er}, 32'd1);
        chk("rd_7ff_rdata", rd, 32'd0);
        req(12'(32'hC03 + NH), 0, 0, rd, er, vl);
        chk("rd_hpm_oob_err", {31'd0, er}, 32'd1);
        chk("rd_hpm_oob_rdata", rd, 32'd0);

        // low/high read pair across a carry
        req(12'hB80, 1, 32'h5, rd, er, vl);
        req(12'hB00, 1, 32'hFFFF_FFFE, rd, er, vl);
        idle(1);
        req(12'hC00, 0, 0, rd, er, vl);
        chk("pair_lo", rd, 32'hFFFF_FFFF);
        req(12'hC80, 0, 0, rd, er, vl);
        chk("pair_hi", rd, SHADOW ? 32'd5 : 32'd6);

        // randomized phase with a mid-run reset
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) rst = 1'b1;
            if (n == 1503) rst = 1'b0;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: a = 12'(legal[$urandom_range(0, legal.size() - 1)]);
                6:       a = 12'h320;
                7:       a = 12'($urandom_range(0, 4095));
                8:       a = 12'(32'hC00 + $urandom_range(0, 255));
                default: a = 12'(32'hB00 + $urandom_range(0, 255));
            endcase
            bus.i_req_valid = ($urandom_range(0, 3) != 0);
            bus.i_req_addr  = a;
            bus.i_req_we    = ($urandom_range(0, 3) == 0);
            bus.i_req_wdata = $urandom_range(0, 1) ? $urandom
                                                   : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
            instret = 1'($urandom_range(0, 1));
            hpm     = NH'($urandom);
            @(posedge clk); #1;
        end
        bus.i_req_valid = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
